// File: rtl/nitro_audio_pkg.sv
// -----------------------------------------------------------------------------
// nitro_audio_pkg
// Constants and types shared by the console I2S transmitter and receiver.
//   AUDIO_SAMPLE_BITS : data bits carried per channel, MSB first
//   AUDIO_SLOT_BITS   : BCLK periods per LRCLK half-frame
//   i2s_state_e       : 2-bit frame-alignment state (HUNT=0, LEFT=1, RIGHT=2)
// -----------------------------------------------------------------------------
package nitro_audio_pkg;

    localparam int AUDIO_SAMPLE_BITS = 16;
    localparam int AUDIO_SLOT_BITS   = 32;

    typedef enum logic [1:0] {
        ST_HUNT  = 2'd0,
        ST_LEFT  = 2'd1,
        ST_RIGHT = 2'd2
    } i2s_state_e;

endpackage : nitro_audio_pkg

// File: rtl/i2s_sync_edge.sv
// -----------------------------------------------------------------------------
// i2s_sync_edge
// Multi-stage synchroniser for the I2S pins. One lane carries the bit clock and
// gets a registered rising-edge detect; the other lanes are plain synchronised
// levels, delayed by the same amount so they line up with the edge pulse.
//   clk          : system clock
//   reset_n      : asynchronous active-low reset
//   edge_pin_i   : asynchronous clock pin (BCLK)
//   level_pin_i  : asynchronous level pins (LRCLK, SDATA)
//   rise_o       : one-clk pulse per rising edge of edge_pin_i
//   level_o      : synchronised level pins, valid in the same cycle as rise_o
// -----------------------------------------------------------------------------
module i2s_sync_edge #(
    parameter int WIDTH       = 2,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             edge_pin_i,
    input  logic [WIDTH-1:0] level_pin_i,
    output logic             rise_o,
    output logic [WIDTH-1:0] level_o
);

    // Lane 0 of every stage is the clock pin, lanes WIDTH:1 are the level pins.
    logic [SYNC_STAGES-1:0][WIDTH:0] sync_q;
    logic                            clk_dly_q;
    logic                            rise_q;
    logic [WIDTH-1:0]                level_q;

    // Synchroniser chain plus one aligning register stage for edge and levels.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync_q    <= '0;
            clk_dly_q <= 1'b0;
            rise_q    <= 1'b0;
            level_q   <= '0;
        end else begin
            sync_q    <= {sync_q[SYNC_STAGES-2:0], {level_pin_i, edge_pin_i}};
            clk_dly_q <= sync_q[SYNC_STAGES-1][0];
            rise_q    <= sync_q[SYNC_STAGES-1][0] & ~clk_dly_q;
            // Levels taken from the same stage that produced the edge decision.
            level_q   <= sync_q[SYNC_STAGES-1][WIDTH:1];
        end
    end

    assign rise_o  = rise_q;
    assign level_o = level_q;

endmodule : i2s_sync_edge

// File: rtl/i2s_receiver.sv
// -----------------------------------------------------------------------------
// i2s_receiver
// Philips-format I2S deserialiser. Oversamples BCLK/LRCLK/SDATA on the system
// clock, aligns to LEFT/RIGHT slots and presents 16-bit stereo pairs.
//   clk          : 50 MHz system clock (>= 8x BCLK)
//   reset_n      : asynchronous active-low reset
//   i2s_bclk     : serial bit clock (asynchronous)
//   i2s_lrclk    : word select, 0 = left, 1 = right
//   i2s_data     : serial data, MSB first
//   sample_l     : last complete left sample
//   sample_r     : last complete right sample
//   sample_valid : one-clk pulse when a new pair is presented
//   locked       : high while aligned to frames
//   frame_error  : one-clk pulse on slot-length violation or BCLK timeout
// -----------------------------------------------------------------------------
module i2s_receiver
    import nitro_audio_pkg::*;
#(
    parameter int SAMPLE_BITS    = AUDIO_SAMPLE_BITS,
    parameter int SLOT_BITS      = AUDIO_SLOT_BITS,
    parameter int SYNC_STAGES    = 2,
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   i2s_bclk,
    input  logic                   i2s_lrclk,
    input  logic                   i2s_data,
    output logic [SAMPLE_BITS-1:0] sample_l,
    output logic [SAMPLE_BITS-1:0] sample_r,
    output logic                   sample_valid,
    output logic                   locked,
    output logic                   frame_error
);

    localparam int BCW = $clog2(SAMPLE_BITS + 1);
    localparam int SCW = $clog2(SLOT_BITS + 2);
    localparam int ICW = $clog2(TIMEOUT_CYCLES + 1);

    logic       edge_s;
    logic [1:0] lvl_s;
    logic       lr_s;
    logic       data_s;

    i2s_sync_edge #(
        .WIDTH       (2),
        .SYNC_STAGES (SYNC_STAGES)
    ) u_sync (
        .clk         (clk),
        .reset_n     (reset_n),
        .edge_pin_i  (i2s_bclk),
        .level_pin_i ({i2s_data, i2s_lrclk}),
        .rise_o      (edge_s),
        .level_o     (lvl_s)
    );

    assign lr_s   = lvl_s[0];
    assign data_s = lvl_s[1];

    i2s_state_e             state_q,     state_d;
    logic                   lr_prev_q,   lr_prev_d;
    logic [SCW-1:0]         slot_cnt_q,  slot_cnt_d;
    logic [BCW-1:0]         bit_cnt_q,   bit_cnt_d;
    logic [ICW-1:0]         idle_cnt_q,  idle_cnt_d;
    logic [SAMPLE_BITS-1:0] shift_q,     shift_d;
    logic [SAMPLE_BITS-1:0] left_hold_q, left_hold_d;
    logic [SAMPLE_BITS-1:0] sample_l_q,  sample_l_d;
    logic [SAMPLE_BITS-1:0] sample_r_q,  sample_r_d;
    logic                   valid_q,     valid_d;
    logic                   error_q,     error_d;
    logic                   locked_q,    locked_d;

    logic                   transition_s;
    logic                   last_bit_s;
    logic                   slot_ok_s;
    logic                   timeout_s;
    logic [SAMPLE_BITS-1:0] shift_next_s;

    // Next-state logic: per-edge counters, capture and frame-alignment FSM.
    always_comb begin
        transition_s = edge_s && (lr_s != lr_prev_q);
        shift_next_s = {shift_q[SAMPLE_BITS-2:0], data_s};
        // The SAMPLE_BITS-th data edge after a transition completes the word.
        last_bit_s   = edge_s && !transition_s && (bit_cnt_q == BCW'(SAMPLE_BITS - 1));
        // slot_cnt includes the transition edge, so a full slot reads SLOT_BITS.
        slot_ok_s    = (slot_cnt_q == SCW'(SLOT_BITS));
        // An edge clears idle_cnt, so a timeout can never coincide with one.
        timeout_s    = !edge_s && (idle_cnt_q == ICW'(TIMEOUT_CYCLES - 1));

        state_d     = state_q;
        lr_prev_d   = lr_prev_q;
        slot_cnt_d  = slot_cnt_q;
        bit_cnt_d   = bit_cnt_q;
        idle_cnt_d  = idle_cnt_q;
        shift_d     = shift_q;
        left_hold_d = left_hold_q;
        sample_l_d  = sample_l_q;
        sample_r_d  = sample_r_q;
        valid_d     = 1'b0;
        error_d     = 1'b0;

        if (edge_s) begin
            idle_cnt_d = '0;
            lr_prev_d  = lr_s;
            if (transition_s) begin
                // Transition edge carries the previous word's trailing bit.
                slot_cnt_d = SCW'(1);
                bit_cnt_d  = '0;
            end else begin
                if (slot_cnt_q != SCW'(SLOT_BITS + 1)) begin
                    slot_cnt_d = slot_cnt_q + SCW'(1);
                end else begin
                    slot_cnt_d = slot_cnt_q;
                end
                if (bit_cnt_q < BCW'(SAMPLE_BITS)) begin
                    shift_d   = shift_next_s;
                    bit_cnt_d = bit_cnt_q + BCW'(1);
                end else begin
                    bit_cnt_d = bit_cnt_q;
                end
            end
        end else if (idle_cnt_q != ICW'(TIMEOUT_CYCLES)) begin
            idle_cnt_d = idle_cnt_q + ICW'(1);
        end else begin
            idle_cnt_d = idle_cnt_q;
        end

        case (state_q)
            ST_HUNT: begin
                if (transition_s && !lr_s) begin
                    state_d = ST_LEFT;
                end else begin
                    state_d = ST_HUNT;
                end
            end
            ST_LEFT: begin
                if (timeout_s) begin
                    error_d = 1'b1;
                    state_d = ST_HUNT;
                end else if (transition_s) begin
                    if (lr_s && slot_ok_s) begin
                        state_d = ST_RIGHT;
                    end else begin
                        error_d = 1'b1;
                        state_d = ST_HUNT;
                    end
                end else if (last_bit_s) begin
                    left_hold_d = shift_next_s;
                end else begin
                    state_d = ST_LEFT;
                end
            end
            ST_RIGHT: begin
                if (timeout_s) begin
                    error_d = 1'b1;
                    state_d = ST_HUNT;
                end else if (transition_s) begin
                    if (!lr_s && slot_ok_s) begin
                        state_d = ST_LEFT;
                    end else begin
                        error_d = 1'b1;
                        state_d = ST_HUNT;
                    end
                end else if (last_bit_s) begin
                    // Both channels update together so the pair is coherent.
                    sample_l_d = left_hold_q;
                    sample_r_d = shift_next_s;
                    valid_d    = 1'b1;
                end else begin
                    state_d = ST_RIGHT;
                end
            end
            default: begin
                state_d = ST_HUNT;
            end
        endcase

        locked_d = (state_d == ST_LEFT) || (state_d == ST_RIGHT);
    end

    // State and output registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= ST_HUNT;
            lr_prev_q   <= 1'b0;
            slot_cnt_q  <= '0;
            bit_cnt_q   <= '0;
            idle_cnt_q  <= '0;
            shift_q     <= '0;
            left_hold_q <= '0;
            sample_l_q  <= '0;
            sample_r_q  <= '0;
            valid_q     <= 1'b0;
            error_q     <= 1'b0;
            locked_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            lr_prev_q   <= lr_prev_d;
            slot_cnt_q  <= slot_cnt_d;
            bit_cnt_q   <= bit_cnt_d;
            idle_cnt_q  <= idle_cnt_d;
            shift_q     <= shift_d;
            left_hold_q <= left_hold_d;
            sample_l_q  <= sample_l_d;
            sample_r_q  <= sample_r_d;
            valid_q     <= valid_d;
            error_q     <= error_d;
            locked_q    <= locked_d;
        end
    end

    assign sample_l     = sample_l_q;
    assign sample_r     = sample_r_q;
    assign sample_valid = valid_q;
    assign locked       = locked_q;
    assign frame_error  = error_q;

endmodule : i2s_receiver

// File: tb/tb_i2s_receiver.sv
// -----------------------------------------------------------------------------
// tb_i2s_receiver
// Self-checking bench for i2s_receiver. Streams are described as a list of
// LRCLK half-slots; a slot-level model derives the expected pairs and errors.
// -----------------------------------------------------------------------------
module tb_i2s_receiver;

    localparam int SYNC    = 2;
    localparam int LAT     = SYNC + 2;
    localparam int TIMEOUT = 256;

    typedef struct {
        logic        lr;
        int          len;
        logic [15:0] word;
    } slot_t;

    logic        clk;
    logic        reset_n;
    logic        i2s_bclk;
    logic        i2s_lrclk;
    logic        i2s_data;
    logic [15:0] sample_l;
    logic [15:0] sample_r;
    logic        sample_valid;
    logic        locked;
    logic        frame_error;

    int          cyc;
    int          n_checks;
    int          n_errors;
    int          last_rise;
    int          overlap_cnt;
    int          exp_err;
    int          rise0  [0:511];
    int          rise16 [0:511];

    slot_t       slots[$];
    logic [15:0] exp_l[$];
    logic [15:0] exp_r[$];
    int          exp_idx[$];
    logic [15:0] got_l[$];
    logic [15:0] got_r[$];
    int          got_cyc[$];
    int          err_cyc[$];

    i2s_receiver #(
        .SAMPLE_BITS    (16),
        .SLOT_BITS      (32),
        .SYNC_STAGES    (SYNC),
        .TIMEOUT_CYCLES (TIMEOUT)
    ) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .i2s_bclk     (i2s_bclk),
        .i2s_lrclk    (i2s_lrclk),
        .i2s_data     (i2s_data),
        .sample_l     (sample_l),
        .sample_r     (sample_r),
        .sample_valid (sample_valid),
        .locked       (locked),
        .frame_error  (frame_error)
    );

    initial clk = 1'b0;
    always #10 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Output monitor: records every presented pair and every error pulse.
    always @(negedge clk) begin
        if (sample_valid) begin
            got_l.push_back(sample_l);
            got_r.push_back(sample_r);
            got_cyc.push_back(cyc);
        end
        if (frame_error) err_cyc.push_back(cyc);
        if (sample_valid && frame_error) overlap_cnt <= overlap_cnt + 1;
    end

    task automatic apply_reset();
        reset_n   = 1'b0;
        i2s_bclk  = 1'b0;
        i2s_lrclk = 1'b0;
        i2s_data  = 1'b0;
        repeat (4) @(negedge clk);
        reset_n = 1'b1;
        repeat (3) @(negedge clk);
        got_l.delete(); got_r.delete(); got_cyc.delete(); err_cyc.delete();
        slots.delete(); exp_l.delete(); exp_r.delete(); exp_idx.delete();
        overlap_cnt = 0;
        exp_err     = 0;
    endtask

    task automatic add_slot(input logic lr, input int len, input logic [15:0] w);
        slot_t s;
        s.lr = lr; s.len = len; s.word = w;
        slots.push_back(s);
    endtask

    task automatic add_frame(input logic [15:0] l, input logic [15:0] r);
        add_slot(1'b0, 32, l);
        add_slot(1'b1, 32, r);
    endtask

    // Slot-level reference: each slot start is an LRCLK change that also
    // closes the previous slot; a word is complete once 17 BCLKs elapsed.
    task automatic run_model(input int first, input int last);
        int          st;
        logic [15:0] lw;
        logic        prev_lr;
        int          prev_len;
        st       = 0;
        lw       = 16'h0000;
        prev_lr  = (first == 0) ? 1'b0 : slots[first-1].lr;
        prev_len = 0;
        for (int i = first; i <= last; i++) begin
            if (slots[i].lr != prev_lr) begin
                if (st == 0) begin
                    if (slots[i].lr == 1'b0) st = 1;
                end else if (st == 1) begin
                    if (slots[i].lr == 1'b1 && prev_len == 32) st = 2;
                    else begin st = 0; exp_err++; end
                end else begin
                    if (slots[i].lr == 1'b0 && prev_len == 32) st = 1;
                    else begin st = 0; exp_err++; end
                end
            end
            if (slots[i].len > 16) begin
                if (st == 1) lw = slots[i].word;
                else if (st == 2) begin
                    exp_l.push_back(lw);
                    exp_r.push_back(slots[i].word);
                    exp_idx.push_back(i);
                end
            end
            prev_lr  = slots[i].lr;
            prev_len = slots[i].len;
        end
    endtask

    // Drives nbits BCLK periods of slot idx; data changes while BCLK is low.
    task automatic drive_slot(input int idx, input int nbits, input int half);
        for (int j = 0; j < nbits; j++) begin
            logic d;
            if (j >= 1 && j <= 16) d = slots[idx].word[16-j];
            else                   d = 1'($urandom_range(0, 1));
            @(negedge clk);
            i2s_bclk  = 1'b0;
            i2s_lrclk = slots[idx].lr;
            i2s_data  = d;
            repeat (half - 1) @(negedge clk);
            @(negedge clk);
            i2s_bclk  = 1'b1;
            last_rise = cyc;
            if (j == 0)  rise0[idx]  = cyc;
            if (j == 16) rise16[idx] = cyc;
            repeat (half - 1) @(negedge clk);
        end
    endtask

    task automatic drive_range(input int first, input int last, input int half);
        for (int i = first; i <= last; i++) drive_slot(i, slots[i].len, half);
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            i2s_bclk  = 1'($urandom_range(0, 1));
            i2s_lrclk = 1'($urandom_range(0, 1));
            i2s_data  = 1'($urandom_range(0, 1));
            n_checks++;
            if ({sample_l, sample_r, sample_valid, locked, frame_error} !== 35'd0) begin
                n_errors++;
                $display("FAIL reset_hold: outputs=%h expected 0",
                         {sample_l, sample_r, sample_valid, locked, frame_error});
            end
        end
        apply_reset();
        add_slot(1'b1, 32, 16'($urandom()));
        add_frame(16'($urandom()), 16'($urandom()));
        add_frame(16'($urandom()), 16'($urandom()));
        run_model(0, 4);
        drive_range(0, 3, 4);
        drive_slot(4, 20, 4);
        repeat (2) @(negedge clk);
        n_checks++;
        if (locked !== 1'b1) begin
            n_errors++; $display("FAIL reset_prelock: locked=%b expected 1", locked);
        end
        n_checks++;
        if (got_l.size() !== 2 || exp_l.size() == 0) begin
            n_errors++; $display("FAIL reset_prepairs: got %0d pairs expected 2", got_l.size());
        end else if (sample_l !== exp_l[exp_l.size()-1] || sample_r !== exp_r[exp_r.size()-1]) begin
            n_errors++;
            $display("FAIL reset_prepairs: L=%h R=%h expected L=%h R=%h", sample_l, sample_r,
                     exp_l[exp_l.size()-1], exp_r[exp_r.size()-1]);
        end
        #3 reset_n = 1'b0;
        #1;
        n_checks++;
        if ({sample_l, sample_r, sample_valid, frame_error} !== 34'd0) begin
            n_errors++;
            $display("FAIL reset_async: outputs=%h expected 0",
                     {sample_l, sample_r, sample_valid, frame_error});
        end
        n_checks++;
        if (locked !== 1'b0) begin
            n_errors++; $display("FAIL reset_async_locked: locked=%b expected 0", locked);
        end
    endtask

    task automatic test_clean();
        apply_reset();
        add_slot(1'b1, 32, 16'h0000);
        for (int f = 0; f < 3; f++) add_frame(16'hA5C3, 16'h1234);
        run_model(0, 6);
        drive_range(0, 6, 9);
        repeat (10) @(negedge clk);
        n_checks++;
        if (got_l.size() !== exp_l.size()) begin
            n_errors++; $display("FAIL clean_count: got %0d expected %0d", got_l.size(), exp_l.size());
        end
        for (int i = 0; i < got_l.size() && i < exp_l.size(); i++) begin
            n_checks++;
            if (got_l[i] !== exp_l[i] || got_r[i] !== exp_r[i]) begin
                n_errors++;
                $display("FAIL clean_pair[%0d]: L=%h R=%h expected L=%h R=%h",
                         i, got_l[i], got_r[i], exp_l[i], exp_r[i]);
            end
            n_checks++;
            if (got_cyc[i] - rise16[exp_idx[i]] !== LAT) begin
                n_errors++;
                $display("FAIL clean_latency[%0d]: %0d clk expected %0d",
                         i, got_cyc[i] - rise16[exp_idx[i]], LAT);
            end
        end
        n_checks++;
        if (err_cyc.size() !== exp_err) begin
            n_errors++; $display("FAIL clean_errors: got %0d expected %0d", err_cyc.size(), exp_err);
        end
        n_checks++;
        if (locked !== 1'b1) begin
            n_errors++; $display("FAIL clean_locked: locked=%b expected 1", locked);
        end
    endtask

    task automatic test_mid_frame();
        apply_reset();
        add_slot(1'b1, 20, 16'($urandom()));
        add_frame(16'($urandom()), 16'($urandom()));
        add_frame(16'($urandom()), 16'($urandom()));
        run_model(0, 4);
        drive_range(0, 4, 4);
        repeat (10) @(negedge clk);
        n_checks++;
        if (got_l.size() !== exp_l.size()) begin
            n_errors++; $display("FAIL mid_count: got %0d expected %0d", got_l.size(), exp_l.size());
        end
        for (int i = 0; i < got_l.size() && i < exp_l.size(); i++) begin
            n_checks++;
            if (got_l[i] !== exp_l[i] || got_r[i] !== exp_r[i] ||
                got_cyc[i] - rise16[exp_idx[i]] !== LAT) begin
                n_errors++;
                $display("FAIL mid_pair[%0d]: L=%h R=%h lat=%0d expected L=%h R=%h lat=%0d", i,
                         got_l[i], got_r[i], got_cyc[i] - rise16[exp_idx[i]], exp_l[i], exp_r[i], LAT);
            end
        end
        n_checks++;
        if (err_cyc.size() !== 0) begin
            n_errors++; $display("FAIL mid_errors: got %0d expected 0", err_cyc.size());
        end
    endtask

    task automatic test_short_slot();
        apply_reset();
        add_slot(1'b1, 32, 16'($urandom()));
        add_frame(16'($urandom()), 16'($urandom()));
        add_slot(1'b0, 31, 16'($urandom()));
        add_slot(1'b1, 32, 16'($urandom()));
        add_frame(16'h7FFF, 16'h8000);
        add_frame(16'($urandom()), 16'($urandom()));
        run_model(0, 8);
        drive_range(0, 4, 4);
        repeat (2) @(negedge clk);
        n_checks++;
        if (locked !== 1'b0) begin
            n_errors++; $display("FAIL short_locked: locked=%b expected 0", locked);
        end
        n_checks++;
        if (err_cyc.size() !== 1) begin
            n_errors++; $display("FAIL short_err_pulse: got %0d pulses expected 1", err_cyc.size());
        end else if (err_cyc[0] - rise0[4] !== LAT) begin
            n_errors++;
            $display("FAIL short_err_time: %0d clk after transition expected %0d", err_cyc[0] - rise0[4], LAT);
        end
        n_checks++;
        if (got_l.size() !== 1) begin
            n_errors++; $display("FAIL short_no_pair: got %0d pairs expected 1", got_l.size());
        end
        drive_range(5, 8, 4);
        repeat (10) @(negedge clk);
        n_checks++;
        if (got_l.size() !== exp_l.size()) begin
            n_errors++; $display("FAIL short_count: got %0d expected %0d", got_l.size(), exp_l.size());
        end
        for (int i = 0; i < got_l.size() && i < exp_l.size(); i++) begin
            n_checks++;
            if (got_l[i] !== exp_l[i] || got_r[i] !== exp_r[i]) begin
                n_errors++;
                $display("FAIL short_pair[%0d]: L=%h R=%h expected L=%h R=%h",
                         i, got_l[i], got_r[i], exp_l[i], exp_r[i]);
            end
        end
        n_checks++;
        if (err_cyc.size() !== exp_err) begin
            n_errors++; $display("FAIL short_errors: got %0d expected %0d", err_cyc.size(), exp_err);
        end
    endtask

    task automatic test_bclk_stop();
        int stop_rise;
        apply_reset();
        add_slot(1'b1, 32, 16'($urandom()));
        add_frame(16'($urandom()), 16'($urandom()));
        add_frame(16'($urandom()), 16'($urandom()));
        run_model(0, 4);
        drive_range(0, 4, 4);
        stop_rise = last_rise;
        repeat (300) @(negedge clk);
        n_checks++;
        if (err_cyc.size() !== exp_err + 1) begin
            n_errors++; $display("FAIL stop_err_pulse: got %0d pulses expected %0d", err_cyc.size(), exp_err + 1);
        end else if (err_cyc[0] - stop_rise < TIMEOUT || err_cyc[0] - stop_rise > TIMEOUT + 8) begin
            n_errors++;
            $display("FAIL stop_err_time: %0d clk after last BCLK expected %0d..%0d",
                     err_cyc[0] - stop_rise, TIMEOUT, TIMEOUT + 8);
        end
        n_checks++;
        if (locked !== 1'b0) begin
            n_errors++; $display("FAIL stop_locked: locked=%b expected 0", locked);
        end
        add_frame(16'($urandom()), 16'($urandom()));
        add_frame(16'($urandom()), 16'($urandom()));
        run_model(5, 8);
        drive_range(5, 8, 4);
        repeat (10) @(negedge clk);
        n_checks++;
        if (got_l.size() !== exp_l.size()) begin
            n_errors++; $display("FAIL stop_count: got %0d expected %0d", got_l.size(), exp_l.size());
        end
        for (int i = 0; i < got_l.size() && i < exp_l.size(); i++) begin
            n_checks++;
            if (got_l[i] !== exp_l[i] || got_r[i] !== exp_r[i]) begin
                n_errors++;
                $display("FAIL stop_pair[%0d]: L=%h R=%h expected L=%h R=%h",
                         i, got_l[i], got_r[i], exp_l[i], exp_r[i]);
            end
        end
        n_checks++;
        if (locked !== 1'b1 || err_cyc.size() !== 1) begin
            n_errors++;
            $display("FAIL stop_relock: locked=%b errors=%0d expected locked=1 errors=1", locked, err_cyc.size());
        end
    endtask

    task automatic test_back_to_back();
        apply_reset();
        add_slot(1'b1, 32, 16'($urandom()));
        for (int f = 0; f < 100; f++) add_frame(16'($urandom()), 16'($urandom()));
        run_model(0, 200);
        drive_range(0, 200, 4);
        repeat (10) @(negedge clk);
        n_checks++;
        if (got_l.size() !== exp_l.size()) begin
            n_errors++; $display("FAIL b2b_count: got %0d expected %0d", got_l.size(), exp_l.size());
        end
        for (int i = 0; i < got_l.size() && i < exp_l.size(); i++) begin
            n_checks++;
            if (got_l[i] !== exp_l[i] || got_r[i] !== exp_r[i] ||
                got_cyc[i] - rise16[exp_idx[i]] !== LAT) begin
                n_errors++;
                $display("FAIL b2b_pair[%0d]: L=%h R=%h lat=%0d expected L=%h R=%h lat=%0d", i,
                         got_l[i], got_r[i], got_cyc[i] - rise16[exp_idx[i]], exp_l[i], exp_r[i], LAT);
            end
        end
        n_checks++;
        if (err_cyc.size() !== 0 || overlap_cnt !== 0) begin
            n_errors++;
            $display("FAIL b2b_errors: errors=%0d overlaps=%0d expected 0 and 0", err_cyc.size(), overlap_cnt);
        end
    endtask

    initial begin
        n_checks    = 0;
        n_errors    = 0;
        last_rise   = 0;
        overlap_cnt = 0;
        exp_err     = 0;
        reset_n     = 1'b0;
        i2s_bclk    = 1'b0;
        i2s_lrclk   = 1'b0;
        i2s_data    = 1'b0;
        test_reset();
        test_clean();
        test_mid_frame();
        test_short_slot();
        test_bclk_stop();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule : tb_i2s_receiver
